// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Owns the PC, selects the next PC and
//               flags fetch-side address errors for the F/D register.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_TOP     = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        eret_D,
    input  logic [31:0] epc,
    input  logic        redirect_D,
    input  logic [31:0] target_D,
    input  logic        branch_D,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_F,
    output logic [31:0] PCplus4_F,
    output logic [31:0] PCplus8_F,
    output logic [4:0]  Exccode_F,
    output logic        DelaySlot_F,
    output logic        PCEn_F
);

    logic [31:0] r_pc;
    logic        r_pc_valid;
    logic        w_adel;
    logic        w_squash;

    // Exception entry overrides a stall; eret outranks a concurrent branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
        end else begin
            r_pc_valid <= 1'b1;
            if (exc_req) begin
                r_pc <= EXC_VECTOR;
            end else if (!stall) begin
                if (eret_D) begin
                    r_pc <= epc;
                end else if (redirect_D) begin
                    r_pc <= target_D;
                end else begin
                    r_pc <= r_pc + 32'd4;
                end
            end
        end
    end

    assign w_adel   = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_TOP);
    assign w_squash = !r_pc_valid || w_adel || exc_req || (eret_D && !stall);

    assign imem_addr   = r_pc;
    assign PC_F        = r_pc;
    assign PCplus4_F   = r_pc + 32'd4;
    assign PCplus8_F   = r_pc + 32'd8;
    assign PCEn_F      = r_pc_valid;
    assign Exccode_F   = (r_pc_valid && w_adel) ? EXC_ADEL : 5'd0;
    assign Instr_F     = w_squash ? 32'd0 : imem_rdata;
    assign DelaySlot_F = branch_D && !eret_D && !exc_req;

endmodule
`default_nettype wire
